branch_predict_unit: RTL and testbench
======================================

Name: branch_predict_unit

Overview:
Parametrised branch resolution unit with a bimodal branch history table (BHT) of 2-bit saturating counters.
- Fetch side: looks up a taken/not-taken prediction per PC.
- Execute side: resolves the real outcome using the same BRANCH_* condition encodings as the branch unit, detects mispredictions and produces a registered redirect PC and pipeline flush.
- Replaces the purely combinational branch decision in the rv32i core; also keeps saturating branch/mispredict statistics counters.

Parameters:
DATA_WIDTH, 32, width of PC, operands and targets (from pkg_config)
BHT_DEPTH, 64, number of 2-bit counters; power of two, >= 2
CNT_WIDTH, 16, width of statistics counters
BHT_INIT, 2'b01, reset value of every BHT counter (weakly not-taken)

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
lookup_valid_i  in  1  fetch requests a prediction this cycle
lookup_pc_i  in  DATA_WIDTH  PC of fetched instruction
pred_valid_o  out  1  prediction valid (one cycle after lookup_valid_i)
pred_taken_o  out  1  predicted direction for the previous cycle's lookup
resolve_valid_i  in  1  execute stage presents a branch/jump
resolve_pc_i  in  DATA_WIDTH  PC of resolving instruction
branch_op_i  in  3  BRANCH_* encoding from pkg_config
a_i  in  DATA_WIDTH  rs1 operand
b_i  in  DATA_WIDTH  rs2 operand
target_i  in  DATA_WIDTH  computed branch/jump target
pred_taken_i  in  1  prediction carried down the pipe with this instruction
take_o  out  1  registered actual outcome
mispredict_o  out  1  registered one-cycle flush pulse
redirect_pc_o  out  DATA_WIDTH  registered correct next PC, valid when mispredict_o=1
clear_stats_i  in  1  synchronous clear of statistics counters
branch_count_o  out  CNT_WIDTH  resolved instructions, saturating
mispredict_count_o  out  CNT_WIDTH  mispredictions, saturating

Behaviour:
- Reset (rst_ni=0, asynchronous): all BHT entries = BHT_INIT; all outputs and counters = 0. A resolve in flight is discarded and produces no pulse after reset release.
- Index: idx = pc[$clog2(BHT_DEPTH)+1:2]; PC bits [1:0] are ignored.
- Lookup: pred_valid_o <= lookup_valid_i; pred_taken_o <= BHT[idx][1]. Latency is 1 cycle. When lookup_valid_i=0, pred_taken_o <= 0.
- Condition by branch_op_i:
  - BEQ: a==b
  - BNE: a!=b
  - BLT: signed a<b
  - BGE: signed a>=b
  - BLTU: unsigned a<b
  - BGEU: unsigned a>=b
  - JAL_JALR: always taken
  - Any other encoding: not taken
- Resolve (resolve_valid_i=1), registered, outputs valid the next cycle:
  - take_o <= actual; mispredict_o <= (actual != pred_taken_i).
  - redirect_pc_o <= actual ? target_i : resolve_pc_i + 4 (wraps modulo 2^DATA_WIDTH).
  - When resolve_valid_i=0: take_o <= 0, mispredict_o <= 0, redirect_pc_o holds its value.
- BHT update on resolve for conditional ops only (JAL_JALR and undefined ops leave the BHT unchanged):
  - Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  - Taken: +1, saturating at 11. Not taken: -1, saturating at 00.
- Same-index same-cycle lookup and update: lookup returns the pre-update value; the update is visible to lookups from the next cycle.
- Statistics:
  - branch_count_o +1 per resolve; mispredict_count_o +1 per mispredict. Both hold at all-ones.
  - clear_stats_i has priority over increment in the same cycle.

Test Plan:
- Reset, then lookup pc=0x100 -> pred_valid_o=1, pred_taken_o=0 one cycle later; all other outputs 0.
- BEQ a=b=0x5, pc=0x100, pred_taken_i=0 -> take_o=1, mispredict_o=1, redirect_pc_o=target_i=0x200. A second identical resolve -> entry 11, subsequent lookup pred_taken_o=1.
- BLT a=0xFFFFFFFF, b=0x00000001 -> taken. BLTU with same operands -> not taken. With pred_taken_i=1 -> mispredict_o=1, redirect_pc_o=pc+4; resolve_pc_i=0xFFFFFFFC gives redirect_pc_o=0x00000000.
- JAL_JALR with pred_taken_i=1 -> take_o=1, mispredict_o=0; the BHT entry is unchanged (verified by lookup).
- Same cycle: lookup and taken update at pc=0x40 from state 01 -> that lookup returns 0; the next-cycle lookup returns 1.
- CNT_WIDTH=4: 20 mispredicting resolves -> both counters stick at 0xF. clear_stats_i together with a resolve -> both read 0. Assert rst_ni mid-resolve -> no mispredict pulse afterwards.

Source files
------------

// File: rtl/branch_predict_unit.sv
`default_nettype none
// ============================================================================
//  Module   : branch_predict_unit
//  Purpose  : Branch resolution unit with a bimodal branch history table.
//             Fetch side looks up a 2-bit saturating counter per PC and
//             returns a registered taken/not-taken prediction. Execute side
//             evaluates the real branch condition, flags mispredictions, and
//             produces a registered redirect PC plus a one-cycle flush pulse.
//             Saturating counters record resolved branches and mispredicts.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i, rst_ni          clock (rising edge), async active-low reset
//    lookup_valid_i/pc_i    fetch-side prediction request
//    pred_valid_o/taken_o   prediction, one cycle after the request
//    resolve_valid_i        execute stage presents a branch/jump
//    resolve_pc_i           PC of the resolving instruction
//    branch_op_i            BRANCH_* condition encoding
//    a_i, b_i               rs1 / rs2 operands
//    target_i               computed branch/jump target
//    pred_taken_i           prediction carried with the instruction
//    take_o                 registered actual outcome
//    mispredict_o           registered one-cycle flush pulse
//    redirect_pc_o          correct next PC, valid with mispredict_o
//    clear_stats_i          synchronous clear of statistics counters
//    branch_count_o         resolved instructions (saturating)
//    mispredict_count_o     mispredictions (saturating)
// ============================================================================
module branch_predict_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BHT_DEPTH  = 64,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter logic [1:0]  BHT_INIT   = 2'b01
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  // fetch side
  input  logic                  lookup_valid_i,
  input  logic [DATA_WIDTH-1:0] lookup_pc_i,
  output logic                  pred_valid_o,
  output logic                  pred_taken_o,
  // execute side
  input  logic                  resolve_valid_i,
  input  logic [DATA_WIDTH-1:0] resolve_pc_i,
  input  logic [2:0]            branch_op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [DATA_WIDTH-1:0] target_i,
  input  logic                  pred_taken_i,
  output logic                  take_o,
  output logic                  mispredict_o,
  output logic [DATA_WIDTH-1:0] redirect_pc_o,
  // statistics
  input  logic                  clear_stats_i,
  output logic [CNT_WIDTH-1:0]  branch_count_o,
  output logic [CNT_WIDTH-1:0]  mispredict_count_o
);

  // --------------------------------------------------------------------------
  // Branch condition encodings (shared with the core's branch unit; the
  // conditional ones follow RISC-V funct3).
  // --------------------------------------------------------------------------
  localparam logic [2:0] BRANCH_BEQ      = 3'b000;
  localparam logic [2:0] BRANCH_BNE      = 3'b001;
  localparam logic [2:0] BRANCH_JAL_JALR = 3'b010;
  localparam logic [2:0] BRANCH_BLT      = 3'b100;
  localparam logic [2:0] BRANCH_BGE      = 3'b101;
  localparam logic [2:0] BRANCH_BLTU     = 3'b110;
  localparam logic [2:0] BRANCH_BGEU     = 3'b111;

  localparam int unsigned IDX_W = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;

  localparam logic [CNT_WIDTH-1:0]  CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

  // --------------------------------------------------------------------------
  // Table indexing: word-aligned PCs, so bits [1:0] never select an entry.
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] resolve_idx;

  assign lookup_idx  = lookup_pc_i[IDX_W+1:2];
  assign resolve_idx = resolve_pc_i[IDX_W+1:2];

  // PC bits outside the index window are intentionally ignored on lookup.
  logic unused_lookup_pc;
  assign unused_lookup_pc = ^{lookup_pc_i[1:0], lookup_pc_i[DATA_WIDTH-1:IDX_W+2]};

  // --------------------------------------------------------------------------
  // Branch history table storage
  // --------------------------------------------------------------------------
  logic [1:0] bht_q [BHT_DEPTH];
  logic       bht_we;
  logic [1:0] bht_upd_d;

  // --------------------------------------------------------------------------
  // Branch condition evaluation
  // --------------------------------------------------------------------------
  logic cond_eq;
  logic cond_lt_s;
  logic cond_lt_u;
  logic actual_taken;
  logic is_conditional;

  assign cond_eq   = (a_i == b_i);
  assign cond_lt_s = ($signed(a_i) < $signed(b_i));
  assign cond_lt_u = (a_i < b_i);

  always_comb begin
    actual_taken   = 1'b0;
    is_conditional = 1'b0;
    unique case (branch_op_i)
      BRANCH_BEQ: begin
        actual_taken   = cond_eq;
        is_conditional = 1'b1;
      end
      BRANCH_BNE: begin
        actual_taken   = ~cond_eq;
        is_conditional = 1'b1;
      end
      BRANCH_BLT: begin
        actual_taken   = cond_lt_s;
        is_conditional = 1'b1;
      end
      BRANCH_BGE: begin
        actual_taken   = ~cond_lt_s;
        is_conditional = 1'b1;
      end
      BRANCH_BLTU: begin
        actual_taken   = cond_lt_u;
        is_conditional = 1'b1;
      end
      BRANCH_BGEU: begin
        actual_taken   = ~cond_lt_u;
        is_conditional = 1'b1;
      end
      // Unconditional jumps are always taken but are not trained into the
      // table: their direction is known, so they would only pollute entries.
      BRANCH_JAL_JALR: begin
        actual_taken   = 1'b1;
        is_conditional = 1'b0;
      end
      default: begin
        actual_taken   = 1'b0;
        is_conditional = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Counter training: saturating increment on taken, decrement on not taken.
  // --------------------------------------------------------------------------
  logic [1:0] bht_cur;

  assign bht_cur = bht_q[resolve_idx];

  always_comb begin
    bht_we    = resolve_valid_i & is_conditional;
    bht_upd_d = bht_cur;
    if (actual_taken) begin
      if (bht_cur != 2'b11) begin
        bht_upd_d = bht_cur + 2'b01;
      end
    end else begin
      if (bht_cur != 2'b00) begin
        bht_upd_d = bht_cur - 2'b01;
      end
    end
  end

  // One register per entry; the lookup path reads the registered value, so a
  // same-cycle lookup of an entry being trained sees the pre-update state.
  for (genvar gi = 0; gi < BHT_DEPTH; gi++) begin : g_bht
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        bht_q[gi] <= BHT_INIT;
      end else if (bht_we && (resolve_idx == IDX_W'(gi))) begin
        bht_q[gi] <= bht_upd_d;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Fetch-side prediction
  // --------------------------------------------------------------------------
  logic pred_valid_q, pred_valid_d;
  logic pred_taken_q, pred_taken_d;

  always_comb begin
    pred_valid_d = lookup_valid_i;
    pred_taken_d = lookup_valid_i & bht_q[lookup_idx][1];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
    end else begin
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
    end
  end

  // --------------------------------------------------------------------------
  // Execute-side resolution and redirect
  // --------------------------------------------------------------------------
  logic                  take_q, take_d;
  logic                  mispredict_q, mispredict_d;
  logic [DATA_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
  logic                  mispredict_now;

  assign mispredict_now = resolve_valid_i & (actual_taken != pred_taken_i);

  always_comb begin
    take_d        = resolve_valid_i & actual_taken;
    mispredict_d  = mispredict_now;
    redirect_pc_d = redirect_pc_q;
    if (resolve_valid_i) begin
      // Fall-through wraps naturally at the top of the address space.
      redirect_pc_d = actual_taken ? target_i : (resolve_pc_i + PC_STEP);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      take_q        <= 1'b0;
      mispredict_q  <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      take_q        <= take_d;
      mispredict_q  <= mispredict_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // --------------------------------------------------------------------------
  // Statistics counters: saturate at all-ones, clear wins over increment.
  // --------------------------------------------------------------------------
  logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_WIDTH-1:0] mispred_cnt_q, mispred_cnt_d;

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (clear_stats_i) begin
      branch_cnt_d  = '0;
      mispred_cnt_d = '0;
    end else begin
      if (resolve_valid_i && (branch_cnt_q != CNT_MAX)) begin
        branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
      end
      if (mispredict_now && (mispred_cnt_q != CNT_MAX)) begin
        mispred_cnt_d = mispred_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign pred_valid_o       = pred_valid_q;
  assign pred_taken_o       = pred_taken_q;
  assign take_o             = take_q;
  assign mispredict_o       = mispredict_q;
  assign redirect_pc_o      = redirect_pc_q;
  assign branch_count_o     = branch_cnt_q;
  assign mispredict_count_o = mispred_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_predict_unit
//  Purpose  : Self-checking bench for branch_predict_unit (CNT_WIDTH = 4).
//             Expected outputs are queued when stimulus is applied and
//             compared one clock later.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predict_unit;

  localparam logic [2:0] BEQ   = 3'b000;
  localparam logic [2:0] BNE   = 3'b001;
  localparam logic [2:0] JAL   = 3'b010;
  localparam logic [2:0] UNDEF = 3'b011;
  localparam logic [2:0] BLT   = 3'b100;
  localparam logic [2:0] BGE   = 3'b101;
  localparam logic [2:0] BLTU  = 3'b110;
  localparam logic [2:0] BGEU  = 3'b111;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        lookup_valid_i;
  logic [31:0] lookup_pc_i;
  logic        pred_valid_o;
  logic        pred_taken_o;
  logic        resolve_valid_i;
  logic [31:0] resolve_pc_i;
  logic [2:0]  branch_op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic [31:0] target_i;
  logic        pred_taken_i;
  logic        take_o;
  logic        mispredict_o;
  logic [31:0] redirect_pc_o;
  logic        clear_stats_i;
  logic [3:0]  branch_count_o;
  logic [3:0]  mispredict_count_o;

  branch_predict_unit #(
    .DATA_WIDTH(32),
    .BHT_DEPTH (64),
    .CNT_WIDTH (4),
    .BHT_INIT  (2'b01)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .lookup_valid_i    (lookup_valid_i),
    .lookup_pc_i       (lookup_pc_i),
    .pred_valid_o      (pred_valid_o),
    .pred_taken_o      (pred_taken_o),
    .resolve_valid_i   (resolve_valid_i),
    .resolve_pc_i      (resolve_pc_i),
    .branch_op_i       (branch_op_i),
    .a_i               (a_i),
    .b_i               (b_i),
    .target_i          (target_i),
    .pred_taken_i      (pred_taken_i),
    .take_o            (take_o),
    .mispredict_o      (mispredict_o),
    .redirect_pc_o     (redirect_pc_o),
    .clear_stats_i     (clear_stats_i),
    .branch_count_o    (branch_count_o),
    .mispredict_count_o(mispredict_count_o)
  );

  always #5 clk_i = ~clk_i;

  // --------------------------------------------------------------------------
  // Scoreboard and reference state
  // --------------------------------------------------------------------------
  typedef struct {
    logic        pv;
    logic        pt;
    logic        take;
    logic        mis;
    logic [31:0] redir;
    logic [3:0]  bc;
    logic [3:0]  mc;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        pt;
    logic        exp_take;
  } vec_t;

  exp_t        sb_q[$];
  logic [1:0]  m_bht [64];
  logic [31:0] m_redir;
  logic [3:0]  m_bc;
  logic [3:0]  m_mc;
  int          n_pass = 0;
  int          n_total = 0;
  vec_t        vecs[13];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endfunction

  function automatic logic is_cond(input logic [2:0] op);
    return (op == BEQ) || (op == BNE) || (op == BLT) || (op == BGE) ||
           (op == BLTU) || (op == BGEU);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
    m_redir = 32'h0;
    m_bc    = 4'h0;
    m_mc    = 4'h0;
    sb_q.delete();
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, "_pred_valid"}, 32'(pred_valid_o), 32'(e.pv));
    chk({tag, "_pred_taken"}, 32'(pred_taken_o), 32'(e.pt));
    chk({tag, "_take"},       32'(take_o),       32'(e.take));
    chk({tag, "_mispredict"}, 32'(mispredict_o), 32'(e.mis));
    chk({tag, "_redirect"},   redirect_pc_o,     e.redir);
    chk({tag, "_br_count"},   32'(branch_count_o),     32'(e.bc));
    chk({tag, "_mis_count"},  32'(mispredict_count_o), 32'(e.mc));
  endtask

  // Apply one cycle of stimulus, queue the expectation, compare after the edge.
  task automatic step(input string tag,
                      input logic lv, input logic [31:0] lpc,
                      input logic rv, input logic [31:0] rpc,
                      input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] tgt,
                      input logic pt, input logic clr, input logic exp_take);
    exp_t        e;
    logic        mis;
    logic [5:0]  li;
    logic [5:0]  ri;
    lookup_valid_i  = lv;
    lookup_pc_i     = lpc;
    resolve_valid_i = rv;
    resolve_pc_i    = rpc;
    branch_op_i     = op;
    a_i             = a;
    b_i             = b;
    target_i        = tgt;
    pred_taken_i    = pt;
    clear_stats_i   = clr;
    li = lpc[7:2];
    ri = rpc[7:2];
    e.pv   = lv;
    e.pt   = lv ? m_bht[li][1] : 1'b0;
    mis    = rv && (exp_take != pt);
    e.take = rv && exp_take;
    e.mis  = mis;
    if (rv) m_redir = exp_take ? tgt : rpc + 32'd4;
    e.redir = m_redir;
    if (clr) begin
      m_bc = 4'h0;
      m_mc = 4'h0;
    end else if (rv) begin
      if (m_bc != 4'hF) m_bc = m_bc + 4'h1;
      if (mis && m_mc != 4'hF) m_mc = m_mc + 4'h1;
    end
    e.bc = m_bc;
    e.mc = m_mc;
    if (rv && is_cond(op)) begin
      if (exp_take && m_bht[ri] != 2'b11) m_bht[ri] = m_bht[ri] + 2'b01;
      else if (!exp_take && m_bht[ri] != 2'b00) m_bht[ri] = m_bht[ri] - 2'b01;
    end
    sb_q.push_back(e);
    @(posedge clk_i);
    #1;
    check_out(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 32'h0, 1'b0, 32'h0, BEQ, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc);
    step(tag, 1'b1, pc, 1'b0, 32'h0, BEQ, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    //          op     a             b             pc            tgt           pt    take
    vecs[0]  = '{BEQ,  32'h5,        32'h5,        32'h100,      32'h200,      1'b0, 1'b1};
    vecs[1]  = '{BEQ,  32'h5,        32'h5,        32'h100,      32'h200,      1'b0, 1'b1};
    vecs[2]  = '{BNE,  32'h5,        32'h5,        32'h104,      32'h300,      1'b0, 1'b0};
    vecs[3]  = '{BNE,  32'h5,        32'h6,        32'h104,      32'h300,      1'b0, 1'b1};
    vecs[4]  = '{BLT,  32'hFFFFFFFF, 32'h1,        32'h108,      32'h400,      1'b1, 1'b1};
    vecs[5]  = '{BLTU, 32'hFFFFFFFF, 32'h1,        32'h108,      32'h400,      1'b1, 1'b0};
    vecs[6]  = '{BGE,  32'h1,        32'hFFFFFFFF, 32'h10C,      32'h500,      1'b0, 1'b1};
    vecs[7]  = '{BGE,  32'h80000000, 32'h7FFFFFFF, 32'h10C,      32'h500,      1'b0, 1'b0};
    vecs[8]  = '{BGEU, 32'h80000000, 32'h7FFFFFFF, 32'h10C,      32'h500,      1'b0, 1'b1};
    vecs[9]  = '{BLTU, 32'hFFFFFFFF, 32'h1,        32'hFFFFFFFC, 32'h600,      1'b1, 1'b0};
    vecs[10] = '{BGE,  32'h5,        32'h5,        32'h118,      32'h700,      1'b0, 1'b1};
    vecs[11] = '{JAL,  32'h0,        32'h0,        32'h110,      32'h800,      1'b1, 1'b1};
    vecs[12] = '{UNDEF,32'h9,        32'h9,        32'h114,      32'h900,      1'b1, 1'b0};

    rst_ni          = 1'b0;
    lookup_valid_i  = 1'b0;
    lookup_pc_i     = 32'h0;
    resolve_valid_i = 1'b0;
    resolve_pc_i    = 32'h0;
    branch_op_i     = BEQ;
    a_i             = 32'h0;
    b_i             = 32'h0;
    target_i        = 32'h0;
    pred_taken_i    = 1'b0;
    clear_stats_i   = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;

    // Reset state
    chk("rst_pred_valid", 32'(pred_valid_o), 32'd0);
    chk("rst_take",       32'(take_o),       32'd0);
    chk("rst_mispredict", 32'(mispredict_o), 32'd0);
    chk("rst_redirect",   redirect_pc_o,     32'd0);
    chk("rst_br_count",   32'(branch_count_o),     32'd0);
    chk("rst_mis_count",  32'(mispredict_count_o), 32'd0);
    rst_ni = 1'b1;

    // Weakly not-taken after reset
    lookup("lk_init_100", 32'h100);

    // Table-driven resolves
    for (int i = 0; i < 13; i++) begin
      step($sformatf("vec%0d", i), 1'b0, 32'h0, 1'b1, vecs[i].pc, vecs[i].op,
           vecs[i].a, vecs[i].b, vecs[i].tgt, vecs[i].pt, 1'b0, vecs[i].exp_take);
      // Directly re-state a few hand-derived redirects.
      if (i == 0) chk("beq_redirect_200", redirect_pc_o, 32'h200);
      if (i == 5) chk("bltu_redirect_pc4", redirect_pc_o, 32'h10C);
      if (i == 9) chk("redirect_wrap", redirect_pc_o, 32'h0);
    end

    // Redirect holds when nothing resolves
    idle("hold");

    // Trained / untouched entries
    lookup("lk_trained_100", 32'h100);
    chk("trained_taken", 32'(pred_taken_o), 32'd1);
    lookup("lk_jal_110", 32'h110);
    chk("jal_no_train", 32'(pred_taken_o), 32'd0);
    lookup("lk_undef_114", 32'h114);

    // Same-cycle lookup and taken update at 0x40: pre-update value seen
    step("same_cycle", 1'b1, 32'h40, 1'b1, 32'h40, BEQ, 32'h7, 32'h7, 32'h80,
         1'b0, 1'b0, 1'b1);
    chk("same_cycle_old", 32'(pred_taken_o), 32'd0);
    lookup("lk_after_40", 32'h40);
    chk("same_cycle_new", 32'(pred_taken_o), 32'd1);

    // Saturation of both statistics counters
    step("clear", 1'b0, 32'h0, 1'b0, 32'h0, BEQ, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step($sformatf("sat%0d", i), 1'b0, 32'h0, 1'b1, 32'h180, BEQ, 32'h1, 32'h2,
           32'hA00, 1'b1, 1'b0, 1'b0);
    end
    chk("br_count_sat",  32'(branch_count_o),     32'hF);
    chk("mis_count_sat", 32'(mispredict_count_o), 32'hF);

    // Clear wins over a simultaneous mispredicting resolve
    step("clr_prio", 1'b0, 32'h0, 1'b1, 32'h180, BEQ, 32'h1, 32'h2, 32'hA00,
         1'b1, 1'b1, 1'b0);
    chk("clr_prio_br",  32'(branch_count_o),     32'h0);
    chk("clr_prio_mis", 32'(mispredict_count_o), 32'h0);

    // Reset asserted while a mispredicting resolve is presented
    resolve_valid_i = 1'b1;
    resolve_pc_i    = 32'h40;
    branch_op_i     = BEQ;
    a_i             = 32'h1;
    b_i             = 32'h2;
    target_i        = 32'hB00;
    pred_taken_i    = 1'b1;
    #2;
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1;
    resolve_valid_i = 1'b0;
    rst_ni          = 1'b1;
    model_reset();
    chk("midrst_mispredict", 32'(mispredict_o), 32'd0);
    chk("midrst_take",       32'(take_o),       32'd0);
    chk("midrst_redirect",   redirect_pc_o,     32'd0);
    idle("post_rst");
    lookup("lk_post_rst_40", 32'h40);
    chk("post_rst_bht_init", 32'(pred_taken_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
